fft_pair_feeder: RTL and testbench



---
 rtl/fft_pair_feeder.sv | 176 +++++++++++++++++
 tb/tb_fft_pair_feeder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_pair_feeder.sv
// Ping-pong sample buffer feeding the radix-2 butterfly with (x[k], x[k+N/2], W_N^k) sets.
// Optional FFT_FEEDER_SCALE_EN halves a/b operands (with rounding) against stage growth.
module fft_pair_feeder #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] in_i,
    input  logic signed [7:0] in_q,
    output logic signed [7:0] a_i,
    output logic signed [7:0] a_q,
    output logic signed [7:0] b_i,
    output logic signed [7:0] b_q,
    output logic signed [7:0] w_i,
    output logic signed [7:0] w_q,
    output logic              data_valid_out,
    output logic              frame_start
);

    localparam int HALF = N / 2;
    localparam int AW   = $clog2(N);
    localparam int KW   = $clog2(HALF);

    if (N != 8 && N != 16) begin : g_bad_n
        $error("fft_pair_feeder: N must be 8 or 16");
    end

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    logic [15:0]        r_mem [0:2*N-1];
    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [AW-1:0]      r_wr_cnt;
    logic [KW-1:0]      r_k;
    state_t             r_state;

    logic signed [7:0]  r_a_i, r_a_q, r_b_i, r_b_q, r_w_i, r_w_q;
    logic               r_valid;
    logic               r_start;

    logic               w_accept;
    logic               w_last_wr;
    logic               w_issue;
    logic               w_last_rd;
    logic [AW:0]        w_a_addr;
    logic [AW:0]        w_b_addr;
    logic [15:0]        w_a_word;
    logic [15:0]        w_b_word;
    logic signed [7:0]  w_tw_i;
    logic signed [7:0]  w_tw_q;
    logic [1:0]         w_full_set;
    logic [1:0]         w_full_clr;

`ifdef FFT_FEEDER_SCALE_EN
    function automatic logic signed [7:0] scale(input logic signed [7:0] x);
        return 8'((9'({x[7], x}) + 9'd1) >> 1);
    endfunction
`else
    function automatic logic signed [7:0] scale(input logic signed [7:0] x);
        return x;
    endfunction
`endif

    assign in_ready  = !r_full[r_wr_bank];
    assign w_accept  = in_valid && !r_full[r_wr_bank];
    assign w_last_wr = w_accept && (r_wr_cnt == AW'(N - 1));

    // In DRAIN the current read bank is always full; the state lets a back-to-back frame skip IDLE.
    assign w_issue   = (r_state == DRAIN) || r_full[r_rd_bank];
    assign w_last_rd = w_issue && (r_k == KW'(HALF - 1));

    assign w_a_addr  = {r_rd_bank, 1'b0, r_k};
    assign w_b_addr  = {r_rd_bank, 1'b1, r_k};
    assign w_a_word  = r_mem[w_a_addr];
    assign w_b_word  = r_mem[w_b_addr];

    assign w_full_set = w_last_wr ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = w_last_rd ? (2'b01 << r_rd_bank) : 2'b00;

    always_comb begin
        w_tw_i = 8'sd0;
        w_tw_q = 8'sd0;
        if (N == 8) begin
            case (int'(r_k))
                0:       begin w_tw_i =  8'sd64; w_tw_q =  8'sd0;  end
                1:       begin w_tw_i =  8'sd45; w_tw_q = -8'sd45; end
                2:       begin w_tw_i =  8'sd0;  w_tw_q = -8'sd64; end
                default: begin w_tw_i = -8'sd45; w_tw_q = -8'sd45; end
            endcase
        end else begin
            case (int'(r_k))
                0:       begin w_tw_i =  8'sd64; w_tw_q =  8'sd0;  end
                1:       begin w_tw_i =  8'sd59; w_tw_q = -8'sd24; end
                2:       begin w_tw_i =  8'sd45; w_tw_q = -8'sd45; end
                3:       begin w_tw_i =  8'sd24; w_tw_q = -8'sd59; end
                4:       begin w_tw_i =  8'sd0;  w_tw_q = -8'sd64; end
                5:       begin w_tw_i = -8'sd24; w_tw_q = -8'sd59; end
                6:       begin w_tw_i = -8'sd45; w_tw_q = -8'sd45; end
                default: begin w_tw_i = -8'sd59; w_tw_q = -8'sd24; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= {in_i, in_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_k       <= '0;
            r_state   <= IDLE;
            r_a_i     <= '0;
            r_a_q     <= '0;
            r_b_i     <= '0;
            r_b_q     <= '0;
            r_w_i     <= '0;
            r_w_q     <= '0;
            r_valid   <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;

            if (w_accept) begin
                r_wr_cnt <= w_last_wr ? '0 : r_wr_cnt + AW'(1);
                if (w_last_wr) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            if (w_issue) begin
                r_a_i   <= scale(w_a_word[15:8]);
                r_a_q   <= scale(w_a_word[7:0]);
                r_b_i   <= scale(w_b_word[15:8]);
                r_b_q   <= scale(w_b_word[7:0]);
                r_w_i   <= w_tw_i;
                r_w_q   <= w_tw_q;
                r_valid <= 1'b1;
                r_start <= (r_k == '0);
                if (w_last_rd) begin
                    r_k       <= '0;
                    r_rd_bank <= ~r_rd_bank;
                    r_state   <= r_full[~r_rd_bank] ? DRAIN : IDLE;
                end else begin
                    r_k     <= r_k + KW'(1);
                    r_state <= DRAIN;
                end
            end else begin
                r_valid <= 1'b0;
                r_start <= 1'b0;
                r_state <= IDLE;
            end
        end
    end

    assign a_i            = r_a_i;
    assign a_q            = r_a_q;
    assign b_i            = r_b_i;
    assign b_q            = r_b_q;
    assign w_i            = r_w_i;
    assign w_q            = r_w_q;
    assign data_valid_out = r_valid;
    assign frame_start    = r_start;

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Directed bench for fft_pair_feeder: an N=8 and an N=16 instance share clock and reset.
module tb_fft_pair_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic              inValid8 = 1'b0;
    logic              inReady8;
    logic signed [7:0] inI8 = '0, inQ8 = '0;
    logic signed [7:0] aI8, aQ8, bI8, bQ8, wI8, wQ8;
    logic              dvo8, fs8;
    logic [47:0]       ops8;

    logic              inValid16 = 1'b0;
    logic              inReady16;
    logic signed [7:0] inI16 = '0, inQ16 = '0;
    logic signed [7:0] aI16, aQ16, bI16, bQ16, wI16, wQ16;
    logic              dvo16, fs16;
    logic [47:0]       ops16;

    int cmpCount = 0;
    int failCount = 0;

    int w8i [4]  = '{64, 45, 0, -45};
    int w8q [4]  = '{0, -45, -64, -45};
    int w16i [8] = '{64, 59, 45, 24, 0, -24, -45, -59};
    int w16q [8] = '{0, -24, -45, -59, -64, -59, -45, -24};

    assign ops8  = {aI8, aQ8, bI8, bQ8, wI8, wQ8};
    assign ops16 = {aI16, aQ16, bI16, bQ16, wI16, wQ16};

    fft_pair_feeder #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8),
        .in_i(inI8), .in_q(inQ8), .a_i(aI8), .a_q(aQ8), .b_i(bI8), .b_q(bQ8),
        .w_i(wI8), .w_q(wQ8), .data_valid_out(dvo8), .frame_start(fs8)
    );

    fft_pair_feeder #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid16), .in_ready(inReady16),
        .in_i(inI16), .in_q(inQ16), .a_i(aI16), .a_q(aQ16), .b_i(bI16), .b_q(bQ16),
        .w_i(wI16), .w_q(wQ16), .data_valid_out(dvo16), .frame_start(fs16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input int i, input int q);
        inValid8 = 1'b1;
        inI8 = 8'(i);
        inQ8 = 8'(q);
        tick();
    endtask

    task automatic push16(input int i, input int q);
        inValid16 = 1'b1;
        inI16 = 8'(i);
        inQ16 = 8'(q);
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        cmpCount++;
        if ({ops8, dvo8, fs8} !== 50'd0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs8: got %h, expected 0", {ops8, dvo8, fs8});
        end
        cmpCount++;
        if ({ops16, dvo16, fs16} !== 50'd0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs16: got %h, expected 0", {ops16, dvo16, fs16});
        end
        cmpCount++;
        if ({inReady8, inReady16} !== 2'b11) begin
            failCount++;
            $display("[TB] FAIL reset_ready: got %b, expected 11", {inReady8, inReady16});
        end
    endtask

    task automatic test_ramp;
        logic [47:0] expOps;
        for (int k = 0; k < 8; k++) push8(10 * k, -k);
        inValid8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            expOps = {8'(10 * k), 8'(-k), 8'(10 * (k + 4)), 8'(-(k + 4)), 8'(w8i[k]), 8'(w8q[k])};
            cmpCount++;
            if ({dvo8, fs8} !== {1'b1, (k == 0)}) begin
                failCount++;
                $display("[TB] FAIL ramp_valid_k%0d: got %b, expected %b", k, {dvo8, fs8}, {1'b1, (k == 0)});
            end
            cmpCount++;
            if (ops8 !== expOps) begin
                failCount++;
                $display("[TB] FAIL ramp_ops_k%0d: got %h, expected %h", k, ops8, expOps);
            end
        end
        tick();
        expOps = {8'(30), 8'(-3), 8'(70), 8'(-7), 8'(-45), 8'(-45)};
        cmpCount++;
        if ({dvo8, fs8, ops8} !== {2'b00, expOps}) begin
            failCount++;
            $display("[TB] FAIL ramp_hold: got %h, expected %h", {dvo8, fs8, ops8}, {2'b00, expOps});
        end
    endtask

    task automatic test_back_to_back;
        int readyLow = 0;
        int valids = 0;
        int starts = 0;
        int startAt [4] = '{-1, -1, -1, -1};
        for (int t = 0; t < 44; t++) begin
            if (t < 32) begin
                inValid8 = 1'b1;
                inI8 = 8'(t);
                inQ8 = 8'(-t);
                if (!inReady8) readyLow++;
            end else begin
                inValid8 = 1'b0;
            end
            tick();
            if (dvo8) valids++;
            if (fs8) begin
                if (starts < 4) startAt[starts] = t;
                starts++;
            end
        end
        cmpCount++;
        if (readyLow !== 0) begin
            failCount++;
            $display("[TB] FAIL b2b_ready_low_cycles: got %0d, expected 0", readyLow);
        end
        cmpCount++;
        if (valids !== 16) begin
            failCount++;
            $display("[TB] FAIL b2b_valid_count: got %0d, expected 16", valids);
        end
        cmpCount++;
        if (starts !== 4) begin
            failCount++;
            $display("[TB] FAIL b2b_start_count: got %0d, expected 4", starts);
        end
        for (int f = 0; f < 4; f++) begin
            cmpCount++;
            if (startAt[f] !== 8 + 8 * f) begin
                failCount++;
                $display("[TB] FAIL b2b_start_cycle%0d: got %0d, expected %0d", f, startAt[f], 8 + 8 * f);
            end
        end
    endtask

    task automatic test_partial;
        int seenValid = 0;
        logic [47:0] expOps;
        for (int k = 0; k < 5; k++) push8(k + 1, 100 + k);
        inValid8 = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (dvo8) seenValid++;
        end
        cmpCount++;
        if (seenValid !== 0) begin
            failCount++;
            $display("[TB] FAIL partial_no_output: got %0d valid cycles, expected 0", seenValid);
        end
        for (int k = 5; k < 8; k++) push8(k + 1, 100 + k);
        inValid8 = 1'b0;
        tick();
        expOps = {8'(1), 8'(100), 8'(5), 8'(104), 8'(64), 8'(0)};
        cmpCount++;
        if ({dvo8, fs8, ops8} !== {2'b11, expOps}) begin
            failCount++;
            $display("[TB] FAIL partial_k0: got %h, expected %h", {dvo8, fs8, ops8}, {2'b11, expOps});
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_reset_mid_drain;
        logic [47:0] expOps;
        for (int k = 0; k < 8; k++) push8(k + 20, k);
        inValid8 = 1'b0;
        tick();
        tick();
        tick();
        expOps = {8'(22), 8'(2), 8'(26), 8'(6), 8'(0), 8'(-64)};
        cmpCount++;
        if (ops8 !== expOps) begin
            failCount++;
            $display("[TB] FAIL middrain_k2: got %h, expected %h", ops8, expOps);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cmpCount++;
        if ({ops8, dvo8, fs8, inReady8} !== {50'd0, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL middrain_reset: got %h, expected %h", {ops8, dvo8, fs8, inReady8}, {50'd0, 1'b1});
        end
        tick();
        cmpCount++;
        if (dvo8 !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL middrain_discard: got %b, expected 0", dvo8);
        end
        for (int k = 0; k < 8; k++) push8(-50 + k, 3 * k);
        inValid8 = 1'b0;
        tick();
        expOps = {8'(-50), 8'(0), 8'(-46), 8'(12), 8'(64), 8'(0)};
        cmpCount++;
        if ({dvo8, fs8, ops8} !== {2'b11, expOps}) begin
            failCount++;
            $display("[TB] FAIL middrain_fresh_k0: got %h, expected %h", {dvo8, fs8, ops8}, {2'b11, expOps});
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_scale;
        logic [47:0] expOps;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) push8(127, -128);
            else if (k == 4) push8(-1, 1);
            else push8(0, 0);
        end
        inValid8 = 1'b0;
        tick();
`ifdef FFT_FEEDER_SCALE_EN
        expOps = {8'(64), 8'(-64), 8'(0), 8'(1), 8'(64), 8'(0)};
`else
        expOps = {8'(127), 8'(-128), 8'(-1), 8'(1), 8'(64), 8'(0)};
`endif
        cmpCount++;
        if ({dvo8, fs8, ops8} !== {2'b11, expOps}) begin
            failCount++;
            $display("[TB] FAIL scale_k0: got %h, expected %h", {dvo8, fs8, ops8}, {2'b11, expOps});
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_n16;
        logic [47:0] expOps;
        for (int k = 0; k < 16; k++) push16((k == 8) ? 64 : 0, 0);
        inValid16 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            expOps = {8'(0), 8'(0), ((k == 0) ? 8'(64) : 8'(0)), 8'(0), 8'(w16i[k]), 8'(w16q[k])};
            cmpCount++;
            if ({dvo16, fs16, ops16} !== {1'b1, (k == 0), expOps}) begin
                failCount++;
                $display("[TB] FAIL n16_k%0d: got %h, expected %h", k, {dvo16, fs16, ops16}, {1'b1, (k == 0), expOps});
            end
        end
        tick();
        cmpCount++;
        if (dvo16 !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL n16_valid_end: got %b, expected 0", dvo16);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_partial();
        test_reset_mid_drain();
        test_scale();
        test_n16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
